// File: rtl/irq_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sched_pkg
//  Description : Shared constants for the machine-mode interrupt scheduler.
//                It holds the mcause codes for the three interrupt classes
//                and the 2-bit encoding of the handshake FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package irq_sched_pkg;

    // mcause interrupt codes, also used as the class tag of a request
    localparam logic [3:0] IRQ_CODE_MEI = 4'd11;
    localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
    localparam logic [3:0] IRQ_CODE_MTI = 4'd7;

    // Request / acknowledge / mret handshake states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } irq_state_e;

endpackage : irq_sched_pkg
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Parameterised lowest-index priority encoder.
//                req_i   - request vector (N bits)
//                idx_o   - index of the lowest set bit, 0 when none is set
//                valid_o - at least one request bit is set
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Scan from the top down so that the lowest set index is written last.
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = W'(i);
            end
        end
    end

endmodule : irq_prio_enc
`default_nettype wire

// File: rtl/irq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sched
//  Description : Machine-mode interrupt scheduler. Latches rising edges on the
//                external lines, masks timer / software / external classes
//                with the CSR enables, selects one winner (MEI > MSI > MTI,
//                lowest external index first) and runs a req/ack handshake
//                with the exception unit, holding off until mret.
//  Ports       : clk_i, reset_i (async, active high)
//                lic_timer_interrupt_i, lic_sw_interrupt_i - level sources
//                ext_irq_i[NEXT]       - edge-triggered external lines
//                csr_*_i               - global and per-class enables
//                excp_irq_ack_i        - trap taken (pulse, honoured in REQ)
//                excp_mret_i           - mret retired (pulse, honoured in SERVICE)
//                irq_req_o, irq_code_o, irq_ext_id_o - request to exception unit
//                ext_pending_o         - latched external pending bits
//                irq_in_service_o      - handler active
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sched
    import irq_sched_pkg::*;
#(
    parameter int NEXT = 4,
    parameter int IDW  = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            lic_timer_interrupt_i,
    input  logic            lic_sw_interrupt_i,
    input  logic [NEXT-1:0] ext_irq_i,
    input  logic            csr_mstatus_mie_i,
    input  logic            csr_mie_mtie_i,
    input  logic            csr_mie_msie_i,
    input  logic            csr_mie_meie_i,
    input  logic            excp_irq_ack_i,
    input  logic            excp_mret_i,
    output logic            irq_req_o,
    output logic [3:0]      irq_code_o,
    output logic [IDW-1:0]  irq_ext_id_o,
    output logic [NEXT-1:0] ext_pending_o,
    output logic            irq_in_service_o
);

    irq_state_e      state_q;
    logic            irq_req_q;
    logic [3:0]      irq_code_q;
    logic [IDW-1:0]  irq_ext_id_q;
    logic            in_service_q;

    logic [NEXT-1:0] ext_prev_q;
    logic [NEXT-1:0] ext_pend_q;
    logic [NEXT-1:0] ext_pend_d;
    logic [NEXT-1:0] ext_set;
    logic [NEXT-1:0] ext_clr;

    logic            enc_valid;
    logic [IDW-1:0]  enc_id;

    logic            mei_elig;
    logic            msi_elig;
    logic            mti_elig;
    logic            any_elig;
    logic [3:0]      sel_code;
    logic [IDW-1:0]  sel_id;
    logic            cap_elig;
    logic            ack_take;

    irq_prio_enc #(
        .N (NEXT),
        .W (IDW)
    ) u_ext_enc (
        .req_i   (ext_pend_q),
        .idx_o   (enc_id),
        .valid_o (enc_valid)
    );

    assign mei_elig = enc_valid & csr_mie_meie_i & csr_mstatus_mie_i;
    assign msi_elig = lic_sw_interrupt_i & csr_mie_msie_i & csr_mstatus_mie_i;
    assign mti_elig = lic_timer_interrupt_i & csr_mie_mtie_i & csr_mstatus_mie_i;
    assign any_elig = mei_elig | msi_elig | mti_elig;
    assign ack_take = (state_q == ST_REQ) & excp_irq_ack_i;

    // Fixed-priority class selection; the external id is only meaningful for MEI.
    always_comb begin
        sel_code = IRQ_CODE_MTI;
        sel_id   = '0;
        if (mei_elig) begin
            sel_code = IRQ_CODE_MEI;
            sel_id   = enc_id;
        end else if (msi_elig) begin
            sel_code = IRQ_CODE_MSI;
        end
    end

    // Is the class captured for the outstanding request still eligible?
    always_comb begin
        cap_elig = 1'b0;
        case (irq_code_q)
            IRQ_CODE_MEI: cap_elig = mei_elig;
            IRQ_CODE_MSI: cap_elig = msi_elig;
            IRQ_CODE_MTI: cap_elig = mti_elig;
            default:      cap_elig = 1'b0;
        endcase
    end

    // Pending update: clear the acknowledged line, then OR in new edges so a
    // fresh edge in the ack cycle is not lost.
    always_comb begin
        ext_set = ext_irq_i & ~ext_prev_q;
        ext_clr = '0;
        for (int i = 0; i < NEXT; i++) begin
            if (ack_take && (irq_code_q == IRQ_CODE_MEI) && (irq_ext_id_q == IDW'(i))) begin
                ext_clr[i] = 1'b1;
            end
        end
        ext_pend_d = (ext_pend_q & ~ext_clr) | ext_set;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ext_prev_q <= '0;
            ext_pend_q <= '0;
        end else begin
            ext_prev_q <= ext_irq_i;
            ext_pend_q <= ext_pend_d;
        end
    end

    // Handshake FSM with registered outputs. Code and id are frozen on entry
    // to REQ so a later higher-priority source cannot disturb the handshake.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            irq_req_q    <= 1'b0;
            irq_code_q   <= 4'd0;
            irq_ext_id_q <= '0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_elig) begin
                        state_q      <= ST_REQ;
                        irq_req_q    <= 1'b1;
                        irq_code_q   <= sel_code;
                        irq_ext_id_q <= sel_id;
                    end
                end
                ST_REQ: begin
                    // Ack takes precedence over a simultaneous withdraw.
                    if (excp_irq_ack_i) begin
                        state_q      <= ST_SERVICE;
                        irq_req_q    <= 1'b0;
                        in_service_q <= 1'b1;
                    end else if (!cap_elig) begin
                        state_q      <= ST_IDLE;
                        irq_req_q    <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (excp_mret_i) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    irq_req_q    <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_o        = irq_req_q;
    assign irq_code_o       = irq_code_q;
    assign irq_ext_id_o     = irq_ext_id_q;
    assign ext_pending_o    = ext_pend_q;
    assign irq_in_service_o = in_service_q;

endmodule : irq_sched
`default_nettype wire

// File: tb/tb_irq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_sched
//  Description : Self-checking bench for irq_sched: table-driven vectors,
//                hand-written corner sequences and randomized stimulus
//                compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sched;

    logic       clk;
    logic       rst;
    logic       tmr, sw;
    logic [3:0] ext;
    logic       mie, mtie, msie, meie;
    logic       ack, mret;

    logic       o_req;
    logic [3:0] o_code;
    logic [3:0] o_id;
    logic [3:0] o_pend;
    logic       o_svc;

    int n_checks = 0;
    int n_err    = 0;

    irq_sched #(.NEXT(4), .IDW(4)) dut (
        .clk_i                 (clk),
        .reset_i               (rst),
        .lic_timer_interrupt_i (tmr),
        .lic_sw_interrupt_i    (sw),
        .ext_irq_i             (ext),
        .csr_mstatus_mie_i     (mie),
        .csr_mie_mtie_i        (mtie),
        .csr_mie_msie_i        (msie),
        .csr_mie_meie_i        (meie),
        .excp_irq_ack_i        (ack),
        .excp_mret_i           (mret),
        .irq_req_o             (o_req),
        .irq_code_o            (o_code),
        .irq_ext_id_o          (o_id),
        .ext_pending_o         (o_pend),
        .irq_in_service_o      (o_svc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: 0 = idle, 1 = requesting, 2 = in service
    // ------------------------------------------------------------------
    int         m_state;
    logic [3:0] m_pend, m_prev, m_code, m_id;

    task automatic model_reset();
        m_state = 0; m_pend = 4'd0; m_prev = 4'd0; m_code = 4'd0; m_id = 4'd0;
    endtask

    function automatic logic class_ok(input logic [3:0] code);
        if (!mie) return 1'b0;
        if (code == 4'd11) return meie && (m_pend != 4'd0);
        if (code == 4'd3)  return msie && sw;
        if (code == 4'd7)  return mtie && tmr;
        return 1'b0;
    endfunction

    task automatic model_step();
        logic [3:0] edges, clr;
        int lo;
        if (rst) begin model_reset(); return; end
        edges = ext & ~m_prev;
        clr   = 4'd0;
        if (m_state == 0) begin
            lo = -1;
            for (int i = 3; i >= 0; i--) if (m_pend[i]) lo = i;
            if (mie && meie && lo >= 0) begin
                m_state = 1; m_code = 4'd11; m_id = lo[3:0];
            end else if (mie && msie && sw) begin
                m_state = 1; m_code = 4'd3; m_id = 4'd0;
            end else if (mie && mtie && tmr) begin
                m_state = 1; m_code = 4'd7; m_id = 4'd0;
            end
        end else if (m_state == 1) begin
            if (ack) begin
                m_state = 2;
                if (m_code == 4'd11) clr[m_id] = 1'b1;
            end else if (!class_ok(m_code)) begin
                m_state = 0;
            end
        end else begin
            if (mret) m_state = 0;
        end
        m_pend = (m_pend & ~clr) | edges;
        m_prev = ext;
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [3:0] code,
                           input logic [3:0] id, input logic [3:0] pend, input logic svc);
        chk({tag, ".req"},  {31'd0, o_req}, {31'd0, req});
        chk({tag, ".code"}, {28'd0, o_code}, {28'd0, code});
        chk({tag, ".id"},   {28'd0, o_id},   {28'd0, id});
        chk({tag, ".pend"}, {28'd0, o_pend}, {28'd0, pend});
        chk({tag, ".svc"},  {31'd0, o_svc},  {31'd0, svc});
    endtask

    // One clock: inputs already set; model advances on the same edge, outputs
    // are then sampled 1 time unit later. Pulses are dropped afterwards.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        ack  = 1'b0;
        mret = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic       tmr, sw;
        logic [3:0] ext;
        logic       mie, ack, mret;
        logic       e_req;
        logic [3:0] e_code, e_id, e_pend;
        logic       e_svc;
    } vec_t;

    function automatic vec_t mk(input logic t, input logic s, input logic [3:0] e,
                                input logic m, input logic a, input logic r,
                                input logic rq, input logic [3:0] c, input logic [3:0] d,
                                input logic [3:0] p, input logic sv);
        vec_t v;
        v.tmr = t; v.sw = s; v.ext = e; v.mie = m; v.ack = a; v.mret = r;
        v.e_req = rq; v.e_code = c; v.e_id = d; v.e_pend = p; v.e_svc = sv;
        return v;
    endfunction

    vec_t vt [$];

    initial begin
        // Timer request, service, re-request after mret while level still high
        //        tmr sw  ext   mie ack mret | req code   id    pend  svc
        vt.push_back(mk(1, 0, 4'h0, 1, 0, 0,   1, 4'd7,  4'd0, 4'h0, 0));
        vt.push_back(mk(1, 0, 4'h0, 1, 1, 0,   0, 4'd7,  4'd0, 4'h0, 1));
        vt.push_back(mk(1, 0, 4'h0, 1, 0, 0,   0, 4'd7,  4'd0, 4'h0, 1));
        vt.push_back(mk(1, 0, 4'h0, 1, 0, 1,   0, 4'd7,  4'd0, 4'h0, 0));
        vt.push_back(mk(1, 0, 4'h0, 1, 0, 0,   1, 4'd7,  4'd0, 4'h0, 0));
        vt.push_back(mk(1, 0, 4'h0, 1, 1, 0,   0, 4'd7,  4'd0, 4'h0, 1));
        vt.push_back(mk(0, 0, 4'h0, 1, 0, 1,   0, 4'd7,  4'd0, 4'h0, 0));
        vt.push_back(mk(0, 0, 4'h0, 1, 0, 0,   0, 4'd7,  4'd0, 4'h0, 0));
        // Priority: timer, sw and ext[2] edge together (global enable held off
        // for the edge cycle so the external edge is already latched)
        vt.push_back(mk(1, 1, 4'h4, 0, 0, 0,   0, 4'd7,  4'd0, 4'h4, 0));
        vt.push_back(mk(1, 1, 4'h4, 1, 0, 0,   1, 4'd11, 4'd2, 4'h4, 0));
        vt.push_back(mk(1, 1, 4'h4, 1, 1, 0,   0, 4'd11, 4'd2, 4'h0, 1));
        vt.push_back(mk(1, 1, 4'h4, 1, 0, 1,   0, 4'd11, 4'd2, 4'h0, 0));
        vt.push_back(mk(1, 1, 4'h4, 1, 0, 0,   1, 4'd3,  4'd0, 4'h0, 0));
        vt.push_back(mk(1, 1, 4'h4, 1, 1, 0,   0, 4'd3,  4'd0, 4'h0, 1));
        vt.push_back(mk(1, 0, 4'h4, 1, 0, 1,   0, 4'd3,  4'd0, 4'h0, 0));
        vt.push_back(mk(1, 0, 4'h4, 1, 0, 0,   1, 4'd7,  4'd0, 4'h0, 0));
        vt.push_back(mk(1, 0, 4'h4, 1, 1, 0,   0, 4'd7,  4'd0, 4'h0, 1));
        vt.push_back(mk(0, 0, 4'h4, 1, 0, 1,   0, 4'd7,  4'd0, 4'h0, 0));
        vt.push_back(mk(0, 0, 4'h0, 1, 0, 0,   0, 4'd7,  4'd0, 4'h0, 0));
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1; tmr = 0; sw = 0; ext = 4'h0;
        mie = 0; mtie = 1; msie = 1; meie = 1; ack = 0; mret = 0;
        model_reset();
        #1;
        chk_out("reset", 0, 4'd0, 4'd0, 4'h0, 0);
        tick();
        tick();
        rst = 1'b0;

        // ---- table-driven vectors ----
        for (int k = 0; k < vt.size(); k++) begin
            tmr = vt[k].tmr; sw = vt[k].sw; ext = vt[k].ext;
            mie = vt[k].mie; ack = vt[k].ack; mret = vt[k].mret;
            tick();
            chk_out($sformatf("vec%0d", k), vt[k].e_req, vt[k].e_code,
                    vt[k].e_id, vt[k].e_pend, vt[k].e_svc);
        end

        // ---- external ordering: lines 3 and 1 ----
        mie = 1; ext = 4'b1010;
        tick();
        chk_out("ord_latch", 0, 4'd7, 4'd0, 4'b1010, 0);
        tick();
        chk_out("ord_req1", 1, 4'd11, 4'd1, 4'b1010, 0);
        ack = 1; tick();
        chk_out("ord_ack1", 0, 4'd11, 4'd1, 4'b1000, 1);
        mret = 1; tick();
        tick();
        chk_out("ord_req3", 1, 4'd11, 4'd3, 4'b1000, 0);
        ack = 1; tick();
        chk_out("ord_ack3", 0, 4'd11, 4'd3, 4'b0000, 1);
        mret = 1; ext = 4'h0; tick();
        tick();
        chk_out("ord_idle", 0, 4'd11, 4'd3, 4'h0, 0);

        // ---- withdraw on mask drop; then ack together with mask drop ----
        tmr = 1; tick();
        chk_out("wd_req", 1, 4'd7, 4'd0, 4'h0, 0);
        mie = 0; tick();
        chk_out("wd_drop", 0, 4'd7, 4'd0, 4'h0, 0);
        tick();
        chk_out("wd_stay", 0, 4'd7, 4'd0, 4'h0, 0);
        mie = 1; tick();
        chk_out("wd_req2", 1, 4'd7, 4'd0, 4'h0, 0);
        mie = 0; ack = 1; tick();
        chk_out("wd_ackwins", 0, 4'd7, 4'd0, 4'h0, 1);
        mret = 1; tmr = 0; tick();
        chk_out("wd_mret", 0, 4'd7, 4'd0, 4'h0, 0);
        mie = 1;

        // ---- set/clear race on line 0 ----
        ext = 4'h1; tick();
        tick();
        chk_out("race_req", 1, 4'd11, 4'd0, 4'h1, 0);
        ext = 4'h0; tick();
        ext = 4'h1; ack = 1; tick();
        chk_out("race_ack", 0, 4'd11, 4'd0, 4'h1, 1);
        mret = 1; tick();
        tick();
        chk_out("race_rereq", 1, 4'd11, 4'd0, 4'h1, 0);
        ack = 1; tick();
        mret = 1; ext = 4'h0; tick();

        // ---- reset while in service with pending 0110 ----
        mie = 0; ext = 4'b0110; tick();
        mie = 1; tmr = 1; tick();
        ack = 1; tick();
        chk_out("rs_pre", 0, 4'd11, 4'd1, 4'b0100, 1);
        ext = 4'b0110; tick();
        chk_out("rs_svc", 0, 4'd11, 4'd1, 4'b0100, 1);
        ext = 4'b0000; tick();
        ext = 4'b0110; tick();
        chk_out("rs_pend", 0, 4'd11, 4'd1, 4'b0110, 1);
        #2;
        rst = 1'b1; ext = 4'h0; tmr = 0;
        model_reset();
        #1;
        chk_out("rs_async", 0, 4'd0, 4'd0, 4'h0, 0);
        tick();
        rst = 1'b0;

        // ---- randomized phase against the model ----
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) tmr = ~tmr;
            if ($urandom_range(0, 5) == 0) sw  = ~sw;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) ext[b] = ~ext[b];
            mie  = ($urandom_range(0, 15) != 0);
            mtie = ($urandom_range(0, 7) != 0);
            msie = ($urandom_range(0, 7) != 0);
            meie = ($urandom_range(0, 7) != 0);
            ack  = ($urandom_range(0, 3) == 0);
            mret = ($urandom_range(0, 3) == 0);
            tick();
            chk_out("rand", m_state == 1, m_code, m_id, m_pend, m_state == 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule : tb_irq_sched
`default_nettype wire
